// File: rtl/mem_wb_pipe.sv
// Back-end pipeline block: EX/MEM and MEM/WB registers, data-memory handshake for
// loads/stores, load extraction and forwarding sources for the EX-stage forward unit.
module mem_wb_pipe #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_E,
    input  logic [XLEN-1:0] ALU_out_E,
    input  logic [XLEN-1:0] store_data_E,
    input  logic [REGW-1:0] rd_E,
    input  logic            reg_we_E,
    input  logic            mem_read_E,
    input  logic            mem_write_E,
    input  logic [2:0]      funct3_E,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] EX_MEM_rd,
    output logic [REGW-1:0] rd_M,
    output logic            reg_we_M,
    output logic            load_M,
    output logic [XLEN-1:0] MEM_WB_rd,
    output logic [REGW-1:0] rd_W,
    output logic            reg_we_W,
    output logic            stall_E,
    output logic            misalign_M
);
    localparam int LANES = 4;

    // M-stage state
    logic            valid_m_q,  valid_m_d;
    logic [XLEN-1:0] result_m_q, result_m_d;
    logic [XLEN-1:0] sdata_m_q,  sdata_m_d;
    logic [REGW-1:0] rd_m_q,     rd_m_d;
    logic            we_m_q,     we_m_d;
    logic            read_m_q,   read_m_d;
    logic            write_m_q,  write_m_d;
    logic [2:0]      funct3_m_q, funct3_m_d;

    // W-stage state
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic [REGW-1:0] rd_w_q,     rd_w_d;
    logic            we_w_q,     we_w_d;

    logic            mem_op_m;
    logic            size_b, size_h, size_w;
    logic [1:0]      off_m;
    logic [XLEN-1:0] load_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [7:0]      rbyte [LANES];
    logic [LANES-1:0] lane_sel;

    assign off_m    = result_m_q[1:0];
    assign size_b   = (funct3_m_q[1:0] == 2'b00);
    assign size_h   = (funct3_m_q[1:0] == 2'b01);
    assign size_w   = (funct3_m_q[1:0] == 2'b10);
    assign mem_op_m = valid_m_q && (read_m_q || write_m_q);

    assign misalign_M = mem_op_m && ((size_h && off_m[0]) || (size_w && (off_m != 2'b00)));
    assign mem_req    = mem_op_m && !misalign_M;
    assign mem_we     = write_m_q;
    assign mem_addr   = {result_m_q[XLEN-1:2], 2'b00};
    assign stall_E    = mem_req && !mem_ready;

    // Byte lanes: read-side slicing, write-side replication and lane enables.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE_IDX = 2'(gi);
        assign rbyte[gi]    = mem_rdata[8*gi +: 8];
        assign lane_sel[gi] = size_w
                            || (size_h && (off_m[1] == LANE_IDX[1]))
                            || (size_b && (off_m == LANE_IDX));
        assign mem_be[gi]   = mem_req && lane_sel[gi];
        assign mem_wdata[8*gi +: 8] = size_b ? sdata_m_q[7:0]
                                    : size_h ? sdata_m_q[8*(gi%2) +: 8]
                                    :          sdata_m_q[8*gi +: 8];
    end

    always_comb begin
        sel_byte  = rbyte[off_m];
        sel_half  = off_m[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};
        load_data = mem_rdata;
        case (funct3_m_q)
            3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    // M register: advance from E unless a memory access is still outstanding.
    always_comb begin
        valid_m_d  = valid_m_q;
        result_m_d = result_m_q;
        sdata_m_d  = sdata_m_q;
        rd_m_d     = rd_m_q;
        we_m_d     = we_m_q;
        read_m_d   = read_m_q;
        write_m_d  = write_m_q;
        funct3_m_d = funct3_m_q;
        if (!stall_E) begin
            valid_m_d  = valid_E;
            result_m_d = ALU_out_E;
            sdata_m_d  = store_data_E;
            rd_m_d     = rd_E;
            we_m_d     = reg_we_E && valid_E && (rd_E != '0);
            read_m_d   = mem_read_E && valid_E;
            write_m_d  = mem_write_E && valid_E;
            funct3_m_d = funct3_E;
        end
    end

    // W register: bubble while stalled; stores and misaligned accesses never write.
    always_comb begin
        wb_data_d = wb_data_q;
        rd_w_d    = rd_w_q;
        we_w_d    = 1'b0;
        if (!stall_E) begin
            wb_data_d = read_m_q ? load_data : result_m_q;
            rd_w_d    = rd_m_q;
            we_w_d    = we_m_q && valid_m_q && !misalign_M && !write_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_m_q  <= 1'b0;
            result_m_q <= '0;
            sdata_m_q  <= '0;
            rd_m_q     <= '0;
            we_m_q     <= 1'b0;
            read_m_q   <= 1'b0;
            write_m_q  <= 1'b0;
            funct3_m_q <= '0;
            wb_data_q  <= '0;
            rd_w_q     <= '0;
            we_w_q     <= 1'b0;
        end else begin
            valid_m_q  <= valid_m_d;
            result_m_q <= result_m_d;
            sdata_m_q  <= sdata_m_d;
            rd_m_q     <= rd_m_d;
            we_m_q     <= we_m_d;
            read_m_q   <= read_m_d;
            write_m_q  <= write_m_d;
            funct3_m_q <= funct3_m_d;
            wb_data_q  <= wb_data_d;
            rd_w_q     <= rd_w_d;
            we_w_q     <= we_w_d;
        end
    end

    assign EX_MEM_rd = result_m_q;
    assign rd_M      = rd_m_q;
    assign reg_we_M  = we_m_q;
    assign load_M    = valid_m_q && read_m_q;
    assign MEM_WB_rd = wb_data_q;
    assign rd_W      = rd_w_q;
    assign reg_we_W  = we_w_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios, then a random instruction stream checked
// against an in-order instruction-level model with its own copy of data memory.
module tb_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_e, reg_we_e, rd_en_e, wr_en_e;
    logic [31:0] alu_e, sdata_e;
    logic [4:0]  rd_e;
    logic [2:0]  f3_e;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] ex_mem_rd, mem_wb_rd;
    logic [4:0]  rd_m, rd_w;
    logic        reg_we_m, load_m, reg_we_w, stall_e, misalign_m;

    int checks = 0;
    int errors = 0;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [4:0] rd; logic [31:0] val; } wb_t;
    req_t        reqq[$];
    wb_t         wbq[$];
    logic [31:0] ref_mem  [16];
    logic [31:0] resp_mem [16];
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always #5 clk = ~clk;

    mem_wb_pipe #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(rst_n), .valid_E(valid_e), .ALU_out_E(alu_e),
        .store_data_E(sdata_e), .rd_E(rd_e), .reg_we_E(reg_we_e),
        .mem_read_E(rd_en_e), .mem_write_E(wr_en_e), .funct3_E(f3_e),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .EX_MEM_rd(ex_mem_rd), .rd_M(rd_m), .reg_we_M(reg_we_m), .load_M(load_m),
        .MEM_WB_rd(mem_wb_rd), .rd_W(rd_w), .reg_we_W(reg_we_w), .stall_E(stall_e),
        .misalign_M(misalign_m)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we, input logic rdn,
                         input logic wrn, input logic [2:0] f3);
        valid_e = v; alu_e = alu; sdata_e = sd; rd_e = rd;
        reg_we_e = we; rd_en_e = rdn; wr_en_e = wrn; f3_e = f3;
    endtask

    task automatic set_idle();
        set_e(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * off);
        case (f3)
            3'd0:    return {{24{v[7]}}, v[7:0]};
            3'd1:    return {{16{v[15]}}, v[15:0]};
            3'd4:    return {24'h0, v[7:0]};
            3'd5:    return {16'h0, v[15:0]};
            default: return word;
        endcase
    endfunction

    // Instruction-level reference: what each accepted instruction must do.
    task automatic model_issue();
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        int          nbytes;
        req_t        r;
        wb_t         w;
        if (!valid_e) return;
        if (rd_en_e || wr_en_e) begin
            mis = (f3_e[1:0] == 2'b01 && alu_e[0]) || (f3_e[1:0] == 2'b10 && alu_e[1:0] != 2'b00);
            if (mis) return;
            nbytes = (f3_e[1:0] == 2'b00) ? 1 : (f3_e[1:0] == 2'b01) ? 2 : 4;
            be = 4'(((1 << nbytes) - 1) << alu_e[1:0]);
            wd = sdata_e << (8 * alu_e[1:0]);
            r.we = wr_en_e; r.addr = {alu_e[31:2], 2'b00}; r.be = be; r.wdata = wd;
            reqq.push_back(r);
            if (wr_en_e) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) ref_mem[alu_e[5:2]][8*k +: 8] = wd[8*k +: 8];
            end else if (reg_we_e && rd_e != 5'd0) begin
                w.rd = rd_e; w.val = extract(ref_mem[alu_e[5:2]], alu_e[1:0], f3_e);
                wbq.push_back(w);
            end
        end else if (reg_we_e && rd_e != 5'd0) begin
            w.rd = rd_e; w.val = alu_e;
            wbq.push_back(w);
        end
    endtask

    task automatic gen_instr();
        int kind;
        kind = $urandom_range(0, 9);
        set_e($urandom_range(0, 7) != 0, $urandom, $urandom, 5'($urandom),
              $urandom_range(0, 3) != 0, 1'b0, 1'b0, 3'($urandom));
        if (kind < 7) begin
            alu_e = 32'h100 + $urandom_range(0, 63);
            if (kind < 4) begin
                rd_en_e = 1'b1; f3_e = ld_f3[$urandom_range(0, 4)];
            end else begin
                wr_en_e = 1'b1; f3_e = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 1) alu_e[1:0] = 2'b00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        in_req, need_new;
        int          wait_left, total_waits, stall_cycles, n_issued, drain, mis_seen;
        req_t        r;
        wb_t         w;
        const int    N = 400;

        // Reset held two cycles with a valid instruction at E.
        rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        set_e(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2);
        tick(); tick();
        check_eq("rst_ex_mem_rd", ex_mem_rd, 32'h0);
        check_eq("rst_rd_m", 32'(rd_m), 32'h0);
        check_eq("rst_reg_we_m", 32'(reg_we_m), 32'h0);
        check_eq("rst_reg_we_w", 32'(reg_we_w), 32'h0);
        check_eq("rst_mem_wb_rd", mem_wb_rd, 32'h0);
        check_eq("rst_stall", 32'(stall_e), 32'h0);
        check_eq("rst_mem_be", 32'(mem_be), 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("alu_m_data", ex_mem_rd, 32'h1234);
        check_eq("alu_m_rd", 32'(rd_m), 32'd5);
        check_eq("alu_m_we", 32'(reg_we_m), 32'd1);
        set_e(1'b1, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        check_eq("alu_w_data", mem_wb_rd, 32'h1234);
        check_eq("alu_w_rd", 32'(rd_w), 32'd5);
        check_eq("alu_w_we", 32'(reg_we_w), 32'd1);
        check_eq("x0_m_we", 32'(reg_we_m), 32'd0);
        set_idle();
        tick();
        check_eq("x0_w_we", 32'(reg_we_w), 32'd0);

        // LB 0x103 with two wait cycles.
        mem_rdata = 32'h80AABBCC;
        set_e(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        set_idle();
        check_eq("lb_req", 32'(mem_req), 32'd1);
        check_eq("lb_addr", mem_addr, 32'h100);
        check_eq("lb_load_m", 32'(load_m), 32'd1);
        check_eq("lb_stall1", 32'(stall_e), 32'd1);
        tick();
        check_eq("lb_stall2", 32'(stall_e), 32'd1);
        check_eq("lb_bubble_w", 32'(reg_we_w), 32'd0);
        tick();
        mem_ready = 1'b1; #1;
        check_eq("lb_ready_nostall", 32'(stall_e), 32'd0);
        tick();
        mem_ready = 1'b0;
        check_eq("lb_data", mem_wb_rd, 32'hFFFFFF80);
        check_eq("lb_we_w", 32'(reg_we_w), 32'd1);
        check_eq("lb_rd_w", 32'(rd_w), 32'd7);

        // LBU same address, zero-wait.
        set_e(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'd4);
        tick();
        set_idle();
        mem_ready = 1'b1; #1;
        check_eq("lbu_nostall", 32'(stall_e), 32'd0);
        tick();
        mem_ready = 1'b0;
        check_eq("lbu_data", mem_wb_rd, 32'h00000080);

        // SH 0x202, immediate ready; reg_we_E set but a store must not write.
        set_e(1'b1, 32'h202, 32'h0000BEEF, 5'd9, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        set_idle();
        mem_ready = 1'b1; #1;
        check_eq("sh_req", 32'(mem_req), 32'd1);
        check_eq("sh_we", 32'(mem_we), 32'd1);
        check_eq("sh_be", 32'(mem_be), 32'hC);
        check_eq("sh_wdata_hi", 32'(mem_wdata[31:16]), 32'hBEEF);
        check_eq("sh_addr", mem_addr, 32'h200);
        check_eq("sh_nostall", 32'(stall_e), 32'd0);
        tick();
        mem_ready = 1'b0;
        check_eq("sh_we_w", 32'(reg_we_w), 32'd0);

        // Misaligned LW.
        set_e(1'b1, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        set_idle();
        check_eq("mis_flag", 32'(misalign_m), 32'd1);
        check_eq("mis_req", 32'(mem_req), 32'd0);
        check_eq("mis_stall", 32'(stall_e), 32'd0);
        tick();
        check_eq("mis_we_w", 32'(reg_we_w), 32'd0);

        // Reset during a load wait abandons the access.
        set_e(1'b1, 32'h104, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        set_idle();
        check_eq("rstld_req", 32'(mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("rstld_req_drop", 32'(mem_req), 32'd0);
        check_eq("rstld_stall", 32'(stall_e), 32'd0);
        check_eq("rstld_we_w", 32'(reg_we_w), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rstld_we_w2", 32'(reg_we_w), 32'd0);
        $display("directed phase done checks=%0d", checks);

        // Random instruction stream.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            resp_mem[i] = ref_mem[i];
        end
        in_req = 1'b0; need_new = 1'b1; wait_left = 0; total_waits = 0;
        stall_cycles = 0; n_issued = 0; drain = 0; mis_seen = 0;
        for (int cyc = 0; cyc < 6000 && drain < 12; cyc++) begin
            if (reg_we_w) begin
                check_eq("wbq_nonempty", 32'(wbq.size() > 0), 32'd1);
                if (wbq.size() > 0) begin
                    w = wbq.pop_front();
                    check_eq("wb_rd", 32'(rd_w), 32'(w.rd));
                    check_eq("wb_val", mem_wb_rd, w.val);
                    $display("wb rd=%0d val=%h", rd_w, mem_wb_rd);
                end
            end
            if (need_new) begin
                if (n_issued < N) begin
                    gen_instr();
                    n_issued++;
                end else begin
                    set_idle();
                    drain++;
                end
                need_new = 1'b0;
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_left = $urandom_range(0, 3);
                    total_waits += wait_left;
                end
                mem_ready = 1'b0;
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_mem[mem_addr[5:2]];
                end else begin
                    wait_left--;
                end
            end
            #1;
            if (misalign_m) mis_seen++;
            if (mem_req) begin
                check_eq("reqq_nonempty", 32'(reqq.size() > 0), 32'd1);
                if (reqq.size() > 0) begin
                    r = reqq[0];
                    check_eq("req_addr", mem_addr, r.addr);
                    check_eq("req_we", 32'(mem_we), 32'(r.we));
                    if (r.we) begin
                        check_eq("req_be", 32'(mem_be), 32'(r.be));
                        check_eq("req_wdata", mem_wdata & {{8{r.be[3]}}, {8{r.be[2]}}, {8{r.be[1]}}, {8{r.be[0]}}},
                                 r.wdata & {{8{r.be[3]}}, {8{r.be[2]}}, {8{r.be[1]}}, {8{r.be[0]}}});
                    end
                    if (mem_ready) begin
                        void'(reqq.pop_front());
                        if (r.we)
                            for (int k = 0; k < 4; k++)
                                if (mem_be[k]) resp_mem[mem_addr[5:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                        in_req = 1'b0;
                        $display("mem %s addr=%h be=%b", r.we ? "wr" : "rd", mem_addr, mem_be);
                    end
                end
            end
            if (stall_e) stall_cycles++;
            if (!stall_e) begin
                model_issue();
                need_new = 1'b1;
            end
            tick();
        end
        check_eq("issued_all", 32'(n_issued), 32'(N));
        check_eq("drain_done", 32'(drain), 32'd12);
        check_eq("wbq_empty", 32'(wbq.size()), 32'd0);
        check_eq("reqq_empty", 32'(reqq.size()), 32'd0);
        check_eq("stall_cycles", 32'(stall_cycles), 32'(total_waits));
        $display("random phase misaligned cycles=%0d", mis_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
